// File: rtl/z80_io_pkg.sv
// Shared definitions for the Z80 I/O-space responder: bus FSM states,
// port offsets within the decoded window, and STATUS bit positions.
package z80_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    HOLD,
    VEC
  } io_state_t;

  localparam logic [1:0] PORT_STATUS = 2'd0;
  localparam logic [1:0] PORT_CTRL   = 2'd1;
  localparam logic [1:0] PORT_RXDATA = 2'd2;
  localparam logic [1:0] PORT_TXDATA = 2'd3;

  localparam int unsigned STAT_INT_PEND = 0;
  localparam int unsigned STAT_RX_FULL  = 1;
  localparam int unsigned STAT_TX_FULL  = 2;
  localparam int unsigned STAT_OVR      = 3;

  localparam int unsigned CTRL_IE_RX = 0;
  localparam int unsigned CTRL_IE_TX = 1;

  // Mode-2 vector: base with bits [2:1] replaced by the source id, bit 0 forced low.
  function automatic logic [7:0] int_vector(input logic [7:0] base, input logic src_tx);
    int_vector = {base[7:3], 1'b0, src_tx, 1'b0};
  endfunction

endpackage

// File: rtl/z80_io_byte_buf.sv
// One-entry byte buffer with valid/ready on both sides. A slot freed by an
// output handshake can be refilled in the same cycle.
module z80_io_byte_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;
  logic       out_fire;
  logic       load;

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  // Drain then load: a simultaneous drain and load leaves the buffer full with new data.
  always_comb begin
    out_fire = full_q & out_ready;
    load     = in_valid & (!full_q | out_fire);
    full_d   = full_q;
    data_d   = data_q;
    if (out_fire) full_d = 1'b0;
    if (load) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O-space slave: decodes four ports, stretches the bus cycle with
// WAIT_L, bridges RX/TX byte buffers to the device side, and answers
// interrupt-acknowledge cycles with a mode-2 vector.
module z80_io_responder
  import z80_io_pkg::*;
#(
  parameter logic [7:0]  BASE_PORT   = 8'h10,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  VECTOR_BASE = 8'hE0
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [15:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  input  logic        M1_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  output logic        WAIT_L,
  output logic        INT_L,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  io_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic       ovr_q, ovr_d;
  logic [7:0] rdata_q, rdata_d;

  logic       sel, intack, rd_act, wr_act;
  logic [1:0] offset;
  logic       rx_full, rx_pop;
  logic [7:0] rx_buf_data;
  logic       tx_push, tx_in_ready, tx_drop;
  logic       int_req, vec_src_tx;
  logic [7:0] status, rdata, vector, bus_out;
  logic       bus_oe, commit;
  logic       unused_addr_hi;

  assign offset         = addr_bus[1:0];
  assign sel            = !IORQ_L & M1_L & (addr_bus[7:2] == BASE_PORT[7:2]);
  assign intack         = !IORQ_L & !M1_L;
  assign rd_act         = !RD_L;
  assign wr_act         = !WR_L & RD_L;
  assign unused_addr_hi = ^addr_bus[15:8];

  z80_io_byte_buf u_rx_buf (
    .clk       (clk),
    .rst_n     (rst_L),
    .in_data   (rx_data),
    .in_valid  (rx_valid),
    .in_ready  (rx_ready),
    .out_data  (rx_buf_data),
    .out_valid (rx_full),
    .out_ready (rx_pop)
  );

  z80_io_byte_buf u_tx_buf (
    .clk       (clk),
    .rst_n     (rst_L),
    .in_data   (data_bus),
    .in_valid  (tx_push),
    .in_ready  (tx_in_ready),
    .out_data  (tx_data),
    .out_valid (tx_valid),
    .out_ready (tx_ready)
  );

  // A TX write while full is lost unless the device drains in the same cycle.
  assign tx_drop = !tx_in_ready & !tx_ready;

  // Interrupt request is a pure level of the enabled conditions.
  assign int_req    = (ctrl_q[CTRL_IE_RX] & rx_full) | (ctrl_q[CTRL_IE_TX] & !tx_valid);
  assign INT_L      = !int_req;
  assign vec_src_tx = !(ctrl_q[CTRL_IE_RX] & rx_full) & ctrl_q[CTRL_IE_TX] & !tx_valid;
  assign vector     = int_vector(VECTOR_BASE, vec_src_tx);

  // Read-side register mux, valid as soon as the address is decoded.
  always_comb begin
    status                = '0;
    status[STAT_OVR]      = ovr_q;
    status[STAT_TX_FULL]  = tx_valid;
    status[STAT_RX_FULL]  = rx_full;
    status[STAT_INT_PEND] = int_req;
    rdata                 = '0;
    unique case (offset)
      PORT_STATUS: rdata = status;
      PORT_CTRL:   rdata = {6'b0, ctrl_q};
      PORT_RXDATA: rdata = rx_full ? rx_buf_data : 8'h00;
      default:     rdata = 8'h00;
    endcase
  end

  // Bus FSM and register state.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      ovr_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ovr_q   <= ovr_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic for the bus FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel && (rd_act || !WR_L)) begin
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_STATES);
          end
        end else if (intack) begin
          state_d = VEC;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = HOLD;
      HOLD:    if (IORQ_L) state_d = IDLE;
      VEC:     if (IORQ_L) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-side outputs per state; HOLD replays the byte latched at commit.
  always_comb begin
    WAIT_L  = 1'b1;
    bus_oe  = 1'b0;
    bus_out = rdata;
    commit  = 1'b0;
    unique case (state_q)
      WAIT: begin
        WAIT_L = 1'b0;
        bus_oe = rd_act;
      end
      ACCESS: begin
        bus_oe = rd_act;
        commit = 1'b1;
      end
      HOLD: begin
        bus_oe  = rd_act;
        bus_out = rdata_q;
      end
      VEC: begin
        bus_oe  = 1'b1;
        bus_out = vector;
      end
      default: ;
    endcase
  end

  // Single commit per bus cycle: register writes, RX pop, TX push, overrun flag.
  always_comb begin
    ctrl_d  = ctrl_q;
    ovr_d   = ovr_q;
    rdata_d = rdata_q;
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    if (commit) begin
      if (rd_act) begin
        rdata_d = rdata;
        if (offset == PORT_RXDATA) rx_pop = rx_full;
        if (offset == PORT_STATUS) ovr_d = 1'b0;
      end else if (wr_act) begin
        if (offset == PORT_CTRL) ctrl_d = data_bus[1:0];
        if (offset == PORT_TXDATA) begin
          tx_push = 1'b1;
          if (tx_drop) ovr_d = 1'b1;
        end
      end
    end
  end

  assign data_bus = bus_oe ? bus_out : 'z;

endmodule

// File: tb/tb_z80_io_responder.sv
// Randomized bench for z80_io_responder against a transaction-level model.
module tb_z80_io_responder;

  localparam logic [7:0]  BASE  = 8'h10;
  localparam int unsigned NWAIT = 2;
  localparam logic [7:0]  VBASE = 8'hE0;

  logic        clk = 1'b0;
  logic        rst_L;
  logic [15:0] addr_bus;
  wire  [7:0]  data_bus;
  logic        M1_L, IORQ_L, RD_L, WR_L;
  logic        WAIT_L, INT_L;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        cpu_oe;
  logic [7:0]  cpu_dout;

  assign data_bus = cpu_oe ? cpu_dout : 'z;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (data_bus[g]);
  end

  always #5 clk = ~clk;

  z80_io_responder #(
    .BASE_PORT   (BASE),
    .WAIT_STATES (NWAIT),
    .VECTOR_BASE (VBASE)
  ) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .addr_bus (addr_bus),
    .data_bus (data_bus),
    .M1_L     (M1_L),
    .IORQ_L   (IORQ_L),
    .RD_L     (RD_L),
    .WR_L     (WR_L),
    .WAIT_L   (WAIT_L),
    .INT_L    (INT_L),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]   m_ctrl;
  bit           m_ovr;
  logic [7:0]   m_rx[$];
  logic [7:0]   m_tx[$];
  logic [7:0]   m_tx_last;

  function automatic void m_reset();
    m_ctrl = 2'b00;
    m_ovr  = 1'b0;
    m_rx.delete();
    m_tx.delete();
    m_tx_last = 8'h00;
  endfunction

  function automatic bit m_int_pend();
    return (m_ctrl[0] && m_rx.size() != 0) || (m_ctrl[1] && m_tx.size() == 0);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] off);
    logic [7:0] v;
    v = 8'h00;
    case (off)
      2'd0: begin
        v = 8'(m_ovr) * 8'd8 + 8'(m_tx.size() != 0) * 8'd4
          + 8'(m_rx.size() != 0) * 8'd2 + 8'(m_int_pend());
        m_ovr = 1'b0;
      end
      2'd1: v = 8'(m_ctrl);
      2'd2: if (m_rx.size() != 0) v = m_rx.pop_front();
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic void m_write(input logic [1:0] off, input logic [7:0] d);
    case (off)
      2'd1: m_ctrl = d[1:0];
      2'd3: begin
        if (m_tx.size() == 0) begin
          m_tx.push_back(d);
          m_tx_last = d;
        end else begin
          m_ovr = 1'b1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] m_vector();
    int src;
    src = 0;
    if (m_ctrl[0] && m_rx.size() != 0) src = 0;
    else if (m_ctrl[1] && m_tx.size() == 0) src = 1;
    return (VBASE & 8'hF8) + 8'(src * 2);
  endfunction

  // ---------------- CPU / device drivers ----------------
  task automatic bus_idle();
    M1_L   = 1'b1;
    IORQ_L = 1'b1;
    RD_L   = 1'b1;
    WR_L   = 1'b1;
    cpu_oe = 1'b0;
  endtask

  task automatic io_cycle(input logic [15:0] a, input bit is_wr, input logic [7:0] wd,
                          output logic [7:0] rd, output int waits, output logic [7:0] first_rd);
    @(posedge clk); #1;
    addr_bus = a;
    M1_L     = 1'b1;
    IORQ_L   = 1'b0;
    if (is_wr) begin
      WR_L     = 1'b0;
      cpu_oe   = 1'b1;
      cpu_dout = wd;
    end else begin
      RD_L = 1'b0;
    end
    @(negedge clk);
    waits    = 0;
    first_rd = data_bus;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) first_rd = data_bus;
      if (WAIT_L) break;
      waits++;
    end
    rd = data_bus;
    @(posedge clk); #1;
    bus_idle();
  endtask

  function automatic logic [15:0] port_addr(input logic [1:0] off);
    logic [7:0] lo;
    lo = {BASE[7:2], off};
    return {8'($urandom), lo};
  endfunction

  task automatic post_check(input string tag);
    @(negedge clk);
    chk({tag, ":int_l"},    8'(INT_L),    8'(!m_int_pend()));
    chk({tag, ":rx_ready"}, 8'(rx_ready), 8'(m_rx.size() == 0));
    chk({tag, ":tx_valid"}, 8'(tx_valid), 8'(m_tx.size() != 0));
    chk({tag, ":tx_data"},  tx_data,      m_tx_last);
    chk({tag, ":bus_rel"},  data_bus,     8'hFF);
  endtask

  task automatic do_read(input logic [1:0] off);
    logic [7:0] rd, fr, exp;
    int w;
    io_cycle(port_addr(off), 1'b0, 8'h00, rd, w, fr);
    exp = m_read(off);
    chk($sformatf("rd%0d", off), rd, exp);
    chk($sformatf("rd%0d_t2", off), fr, exp);
    chk($sformatf("rd%0d_waits", off), 8'(w), 8'(NWAIT));
    post_check($sformatf("rd%0d", off));
  endtask

  task automatic do_write(input logic [1:0] off, input logic [7:0] d);
    logic [7:0] rd, fr;
    int w;
    io_cycle(port_addr(off), 1'b1, d, rd, w, fr);
    m_write(off, d);
    chk($sformatf("wr%0d_waits", off), 8'(w), 8'(NWAIT));
    post_check($sformatf("wr%0d", off));
  endtask

  task automatic stray_access(input bit is_wr);
    logic [7:0] lo, rd, fr;
    int w;
    lo = 8'h20;
    if ($urandom_range(0, 1) == 1) begin
      do lo = 8'($urandom); while (lo[7:2] == BASE[7:2]);
    end
    io_cycle({8'($urandom), lo}, is_wr, 8'($urandom), rd, w, fr);
    chk("stray_waits", 8'(w), 8'h00);
    if (!is_wr) chk("stray_bus", rd, 8'hFF);
    post_check("stray");
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    m_rx.push_back(b);
    post_check("rx_push");
  endtask

  task automatic tx_drain();
    @(posedge clk); #1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    if (m_tx.size() != 0) void'(m_tx.pop_front());
    post_check("tx_drain");
  endtask

  task automatic do_intack();
    logic [7:0] exp;
    exp = m_vector();
    @(posedge clk); #1;
    M1_L   = 1'b0;
    IORQ_L = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("vector", data_bus, exp);
    @(posedge clk); #1;
    bus_idle();
    @(posedge clk);
    post_check("intack");
  endtask

  task automatic reset_mid_wait();
    @(posedge clk); #1;
    addr_bus = port_addr(2'd0);
    M1_L     = 1'b1;
    IORQ_L   = 1'b0;
    RD_L     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wait_l", 8'(WAIT_L), 8'h00);
    #2 rst_L = 1'b0;
    #1;
    chk("rst_wait_l", 8'(WAIT_L), 8'h01);
    chk("rst_bus", data_bus, 8'hFF);
    m_reset();
    bus_idle();
    @(posedge clk); #1;
    rst_L = 1'b1;
    post_check("after_rst");
  endtask

  initial begin
    rst_L    = 1'b0;
    addr_bus = '0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    cpu_dout = '0;
    bus_idle();
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wait_l",   8'(WAIT_L),   8'h01);
    chk("reset_int_l",    8'(INT_L),    8'h01);
    chk("reset_bus",      data_bus,     8'hFF);
    chk("reset_rx_ready", 8'(rx_ready), 8'h01);
    chk("reset_tx_valid", 8'(tx_valid), 8'h00);
    chk("reset_tx_data",  tx_data,      8'h00);
    rst_L = 1'b1;

    // control register and TX-empty interrupt
    do_write(2'd1, 8'h03);
    do_read(2'd1);
    do_read(2'd0);

    // RX path, including read of empty RXDATA
    do_write(2'd1, 8'h00);
    rx_push(8'hA5);
    do_read(2'd2);
    do_read(2'd2);

    // TX overrun and its clear-on-read
    do_write(2'd3, 8'h5A);
    do_write(2'd3, 8'h77);
    do_read(2'd0);
    do_read(2'd0);
    tx_drain();

    // interrupt vectors
    do_write(2'd1, 8'h01);
    rx_push(8'h3C);
    do_intack();
    do_read(2'd2);
    do_write(2'd1, 8'h02);
    do_intack();
    do_write(2'd1, 8'h03);
    rx_push(8'hC3);
    do_intack();
    do_read(2'd2);

    // reset mid-cycle and non-matching addresses
    reset_mid_wait();
    stray_access(1'b0);
    stray_access(1'b1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: do_write(2'd1, 8'($urandom));
        1: do_read(2'd0);
        2: do_read(2'd1);
        3: do_read(2'd2);
        4: do_write(2'd3, 8'($urandom));
        5: do_read(2'($urandom_range(2, 3)));
        6: if (m_rx.size() == 0) rx_push(8'($urandom)); else do_read(2'd2);
        7: tx_drain();
        8: do_intack();
        default: begin
          if ($urandom_range(0, 1) == 1) do_write(2'($urandom_range(0, 2)) & 2'b10, 8'($urandom));
          else stray_access(1'($urandom_range(0, 1)));
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
